data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_array.sv | 26 ++
 rtl/data_mem_resp.sv | 101 ++++++++++
 tb/tb_data_mem_resp.sv | 111 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data memory responder: MemOp codes, FSM states,
// array geometry and the load-extension helper.
package dmem_pkg;

  localparam int DEPTH = 16384;
  localparam int AW    = 14;

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } mem_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  // Context captured at acceptance and held for the whole response phase.
  typedef struct packed {
    logic       err;
    logic       load;
    logic [2:0] op;
    logic [1:0] off;
  } rsp_ctx_t;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] op,
                                           input logic [1:0] off);
    logic [31:0] b;
    logic [15:0] h;
    b = w >> {off, 3'b000};
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      OP_B:    load_ext = {{24{b[7]}}, b[7:0]};
      OP_BU:   load_ext = {24'd0, b[7:0]};
      OP_H:    load_ext = {{16{h[15]}}, h};
      OP_HU:   load_ext = {16'd0, h};
      OP_W:    load_ext = w;
      default: load_ext = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// 16384x32 data array: byte-enabled synchronous write, synchronous read, no reset.
module dmem_array
  import dmem_pkg::*;
(
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++)
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Valid/ready data memory responder (IDLE/RESP, one request per two cycles).
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned halves/words instead of force-aligning.
module data_mem_resp
  import dmem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_e      state_q, state_d;
  rsp_ctx_t    ctx_q, ctx_d;
  logic        accept, legal, misal, err;
  logic [3:0]  be, wr_be;
  logic [31:0] wdata, rd;
  logic        unused_addr_hi;

  // Upper address bits wrap silently.
  assign unused_addr_hi = ^req_addr[31:16];

  assign req_ready = reset & (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    legal = 1'b0;
    case (req_op)
      OP_B, OP_H, OP_W: legal = 1'b1;
      OP_BU, OP_HU:     legal = ~req_we;
      default:          legal = 1'b0;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misal = ((req_op[1:0] == 2'b01) & req_addr[0]) |
                 ((req_op == OP_W) & (req_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign err = ~legal | misal;

  always_comb begin
    be    = 4'b0000;
    wdata = req_wdata;
    case (req_op[1:0])
      2'b00: begin be = 4'b0001 << req_addr[1:0]; wdata = {4{req_wdata[7:0]}};  end
      2'b01: begin be = req_addr[1] ? 4'b1100 : 4'b0011; wdata = {2{req_wdata[15:0]}}; end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wr_be = (accept & req_we & ~err) ? be : 4'b0000;

  dmem_array u_array (
    .clk     (clock),
    .en_i    (accept),
    .be_i    (wr_be),
    .addr_i  (req_addr[15:2]),
    .wdata_i (wdata),
    .rdata_o (rd)
  );

  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_RESP;
        ctx_d   = '{err: err, load: ~req_we, op: req_op, off: req_addr[1:0]};
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_valid & ctx_q.err;
  assign rsp_rdata = (rsp_valid & ctx_q.load & ~ctx_q.err) ? load_ext(rd, ctx_q.op, ctx_q.off)
                                                           : 32'd0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed-vector bench for data_mem_resp with hand-computed expectations.
module tb_data_mem_resp;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_op = 3'b000;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_chk = 0, n_pass = 0;

  data_mem_resp dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_op(req_op), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One full transaction: accept, check response in the next cycle, consume.
  task automatic xact(input string tag, input logic we, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, ".rdata"}, rsp_rdata, exp_d);
    chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_e});
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk({tag, ".done"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst.ready", {31'd0, req_ready}, 32'd0);
    chk("rst.valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    chk("rst.err",   {31'd0, rsp_err},   32'd0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("rst.rel_ready", {31'd0, req_ready}, 32'd1);

    xact("sw",   1, 3'b010, 32'h0100, 32'h12345678, 32'h0, 0);
    xact("lw",   0, 3'b010, 32'h0100, 32'h0,        32'h12345678, 0);
    xact("sw1",  1, 3'b010, 32'h0100, 32'hFFFFFFFF, 32'h0, 0);
    xact("sb",   1, 3'b000, 32'h0102, 32'h00000080, 32'h0, 0);
    xact("lb",   0, 3'b000, 32'h0102, 32'h0,        32'hFFFFFF80, 0);
    xact("lbu",  0, 3'b100, 32'h0102, 32'h0,        32'h00000080, 0);
    xact("lw2",  0, 3'b010, 32'h0100, 32'h0,        32'hFF80FFFF, 0);
    xact("lbu1", 0, 3'b100, 32'h0101, 32'h0,        32'h000000FF, 0);
    xact("sh",   1, 3'b001, 32'h0202, 32'h0000BEEF, 32'h0, 0);
    xact("lh",   0, 3'b001, 32'h0202, 32'h0,        32'hFFFFBEEF, 0);
    xact("lhu",  0, 3'b101, 32'h0202, 32'h0,        32'h0000BEEF, 0);

    // Stall: response held 5 cycles while a second request is offered.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h0100;
    @(posedge clock); #1;
    req_we = 1'b1; req_wdata = 32'h55AA55AA;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk($sformatf("stall%0d.valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d.rdata", i), rsp_rdata, 32'hFF80FFFF);
      chk($sformatf("stall%0d.ready", i), {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    xact("stall.chk", 0, 3'b010, 32'h0100, 32'h0, 32'hFF80FFFF, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
    xact("lw_mis", 0, 3'b010, 32'h0102, 32'h0, 32'h0, 1);
`else
    xact("lw_mis", 0, 3'b010, 32'h0102, 32'h0, 32'hFF80FFFF, 0);
`endif
    xact("op111",  1, 3'b111, 32'h0100, 32'hDEADBEEF, 32'h0, 1);
    xact("op111l", 0, 3'b111, 32'h0100, 32'h0,        32'h0, 1);
    xact("sbu",    1, 3'b100, 32'h0100, 32'h00000011, 32'h0, 1);
    xact("unchg",  0, 3'b010, 32'h0100, 32'h0,        32'hFF80FFFF, 0);
    xact("wrap",   0, 3'b010, 32'h00010100, 32'h0,    32'hFF80FFFF, 0);

    // Reset while a store response is pending.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010; req_addr = 32'h0300; req_wdata = 32'hCAFEF00D;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("rrst.pre_valid", {31'd0, rsp_valid}, 32'd1);
    reset = 1'b0; #1;
    chk("rrst.valid", {31'd0, rsp_valid}, 32'd0);
    chk("rrst.ready", {31'd0, req_ready}, 32'd0);
    @(negedge clock); reset = 1'b1;
    xact("rrst.lw", 0, 3'b010, 32'h0300, 32'h0, 32'hCAFEF00D, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
